// File: rtl/nios_system_pwm_fb_pio_in_pkg.sv
// pwm_fb_pio_pkg: shared constants for the PWM feedback input PIO.
// Holds the register map (as an enum) and the edge-type selectors.
package pwm_fb_pio_pkg;

    // Avalon-MM register offsets (word addresses).
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } reg_addr_e;

    // Edge that sets a capture bit.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Avalon data bus width.
    localparam int BUS_W = 32;

endpackage

// File: rtl/nios_system_pwm_fb_pio_in_sync_edge_det.sv
// pio_sync_edge_det: per-bit synchroniser, previous-value flop and edge detector.
// Ports:
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   in_i     asynchronous input lines
//   sync_o   synchronised value (last synchroniser stage)
//   edge_o   per-bit edge pulse, type chosen by EDGE_TYPE
module pio_sync_edge_det
    import pwm_fb_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    // chain_q[0] is the first (metastable) stage.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  prev_d;
    logic [WIDTH-1:0]                  rise_w;
    logic [WIDTH-1:0]                  fall_w;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], in_i};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_w = sync_o & ~prev_q;
    assign fall_w = ~sync_o & prev_q;

    always_comb begin
        edge_o = rise_w;
        case (EDGE_TYPE)
            EDGE_FALL: edge_o = fall_w;
            EDGE_ANY:  edge_o = rise_w | fall_w;
            default:   edge_o = rise_w;
        endcase
    end

endmodule

// File: rtl/nios_system_pwm_fb_pio_in.sv
// nios_system_pwm_fb_pio_in: Avalon-MM input PIO returning PWM/motor feedback
// lines to the Nios II, with per-bit edge capture and a maskable level irq.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   address, chipselect  register select (0 DATA, 2 IRQ_MASK, 3 EDGE_CAPTURE)
//   write_n, writedata   active-low write strobe and write data
//   in_port              asynchronous feedback lines
//   readdata             zero-latency read data
//   irq                  registered interrupt request
// Build option: define PWM_FB_PIO_BIT_CLEAR_EN so that a write to
// EDGE_CAPTURE clears only the bits written as 1 (otherwise it clears all).
module nios_system_pwm_fb_pio_in
    import pwm_fb_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [BUS_W-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [BUS_W-1:0] readdata,
    output logic             irq
);

    reg_addr_e        addr_w;
    logic             wr_en_w;
    logic             wr_mask_w;
    logic             wr_edge_w;
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] clr_w;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic             irq_q;
    logic             irq_d;
    logic             unused_wdata;

    pio_sync_edge_det #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_det (
        .clk_i   (clk),
        .reset_i (reset),
        .in_i    (in_port),
        .sync_o  (sync_w),
        .edge_o  (edge_w)
    );

    assign addr_w    = reg_addr_e'(address);
    assign wr_en_w   = chipselect && !write_n;
    assign wr_mask_w = wr_en_w && (addr_w == ADDR_MASK);
    assign wr_edge_w = wr_en_w && (addr_w == ADDR_EDGE);

    // Upper write-data bits only matter when WIDTH < 32.
    assign unused_wdata = ^writedata;

`ifdef PWM_FB_PIO_BIT_CLEAR_EN
    assign clr_w = writedata[WIDTH-1:0] & {WIDTH{wr_edge_w}};
`else
    assign clr_w = {WIDTH{wr_edge_w}};
`endif

    always_comb begin
        mask_d = mask_q;
        if (wr_mask_w) begin
            mask_d = writedata[WIDTH-1:0];
        end
    end

    // A new edge is OR-ed in after the clear so it is never lost.
    always_comb begin
        cap_d = (cap_q & ~clr_w) | edge_w;
    end

    always_comb begin
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        readdata = '0;
        unique case (addr_w)
            ADDR_DATA: readdata[WIDTH-1:0] = sync_w;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_pwm_fb_pio_in.sv
// tb_nios_system_pwm_fb_pio_in: directed plus random bench for the feedback PIO.
// Three instances (rising, falling, any edge) share one bus and one input vector.
module tb_nios_system_pwm_fb_pio_in;

    localparam int W = 16;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd [3];
    logic          irq_o [3];

    int checks   = 0;
    int failures = 0;

    // Reference state: history of sampled inputs, newest first.
    logic [W-1:0] hist [0:S];
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap [3];
    logic         m_irq [3];

    always #5 clk = ~clk;

    nios_system_pwm_fb_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq_o[0])
    );

    nios_system_pwm_fb_pio_in #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq_o[1])
    );

    nios_system_pwm_fb_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A bit reports an edge if its level moved in the direction of interest.
    function automatic logic [W-1:0] edges_of(input int et, input logic [W-1:0] now,
                                             input logic [W-1:0] was);
        logic [W-1:0] went_up;
        logic [W-1:0] went_dn;
        went_up = now & ~was;
        went_dn = was & ~now;
        if (et == 0) return went_up;
        if (et == 1) return went_dn;
        return went_up | went_dn;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= S; i++) hist[i] = '0;
        m_mask = '0;
        for (int k = 0; k < 3; k++) begin
            m_cap[k] = '0;
            m_irq[k] = 1'b0;
        end
    endtask

    // Advance the reference by one clock using the inputs in effect at the edge.
    task automatic model_edge();
        logic         wr;
        logic [W-1:0] clr;
        if (reset) begin
            model_reset();
            return;
        end
        wr  = chipselect && !write_n;
        clr = '0;
        if (wr && address == 2'd3) begin
`ifdef PWM_FB_PIO_BIT_CLEAR_EN
            clr = writedata[W-1:0];
`else
            clr = '1;
`endif
        end
        for (int k = 0; k < 3; k++) begin
            m_irq[k] = |(m_cap[k] & m_mask);
            m_cap[k] = (m_cap[k] & ~clr) | edges_of(k, hist[S-1], hist[S]);
        end
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
    endtask

    function automatic logic [31:0] exp_rd(input int k);
        logic [31:0] r;
        r = '0;
        case (address)
            2'd0:    r[W-1:0] = hist[S-1];
            2'd2:    r[W-1:0] = m_mask;
            2'd3:    r[W-1:0] = m_cap[k];
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("irq%0d", k), 32'(irq_o[k]), 32'(m_irq[k]));
            chk($sformatf("rd%0d_a%0d", k, address), rd[k], exp_rd(k));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_chk(input string tag, input int k, input logic [1:0] a,
                            input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, rd[k], exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        model_reset();
        repeat (3) cyc();
        read_chk("rst_data", 0, 2'd0, 32'h0);
        read_chk("rst_mask", 0, 2'd2, 32'h0);
        read_chk("rst_cap", 0, 2'd3, 32'h0);
        chk("rst_irq", 32'(irq_o[0]), 32'h0);
        reset = 1'b0;

        // DATA path, writes ignored
        in_port = 16'hA5C3;
        address = 2'd0;
        repeat (3) cyc();
        read_chk("data", 0, 2'd0, 32'h0000A5C3);
        bus_write(2'd0, 32'h0000FFFF);
        read_chk("data_wr_ign", 0, 2'd0, 32'h0000A5C3);
        read_chk("rsvd", 0, 2'd1, 32'h0);
        in_port = '0;
        repeat (4) cyc();
        bus_write(2'd3, 32'hFFFFFFFF);
        read_chk("clr_rise", 0, 2'd3, 32'h0);
        read_chk("clr_any", 2, 2'd3, 32'h0);

        // Rising capture on bit 4, hold, then unmask
        in_port = 16'h0010;
        repeat (2) cyc();
        in_port = '0;
        repeat (4) cyc();
        read_chk("rise_cap", 0, 2'd3, 32'h00000010);
        read_chk("fall_cap", 1, 2'd3, 32'h00000010);
        repeat (20) cyc();
        read_chk("rise_hold", 0, 2'd3, 32'h00000010);
        chk("irq_masked", 32'(irq_o[0]), 32'h0);
        bus_write(2'd2, 32'h00000010);
        chk("irq_lat1", 32'(irq_o[0]), 32'h0);
        cyc();
        chk("irq_on", 32'(irq_o[0]), 32'h1);

`ifdef PWM_FB_PIO_BIT_CLEAR_EN
        in_port = 16'h0001;
        repeat (2) cyc();
        in_port = '0;
        repeat (4) cyc();
        read_chk("cap_0011", 0, 2'd3, 32'h00000011);
        bus_write(2'd3, 32'h00000001);
        read_chk("bit_clr", 0, 2'd3, 32'h00000010);
        bus_write(2'd3, 32'h0000FFFF);
        cyc();
        chk("clr_irq", 32'(irq_o[0]), 32'h0);
`else
        bus_write(2'd3, 32'h0);
        read_chk("clr_all", 0, 2'd3, 32'h0);
        cyc();
        chk("clr_irq", 32'(irq_o[0]), 32'h0);
`endif

        // Clear lands in the same cycle as a new bit-0 edge: set wins
        in_port = 16'h0001;
        cyc();
        cyc();
        bus_write(2'd3, 32'hFFFFFFFF);
        read_chk("set_wins", 0, 2'd3, 32'h00000001);
        in_port = '0;
        repeat (4) cyc();
        bus_write(2'd3, 32'hFFFFFFFF);

        // Any-edge instance: bit 15 up, clear, down
        in_port = 16'h8000;
        repeat (4) cyc();
        read_chk("any_up", 2, 2'd3, 32'h00008000);
        bus_write(2'd3, 32'hFFFFFFFF);
        read_chk("any_clr", 2, 2'd3, 32'h0);
        in_port = '0;
        repeat (4) cyc();
        read_chk("any_dn", 2, 2'd3, 32'h00008000);
        read_chk("rise_no_dn", 0, 2'd3, 32'h0);
        read_chk("fall_dn", 1, 2'd3, 32'h00008000);

        // Asynchronous reset in the middle of a cycle
        bus_write(2'd2, 32'h0000FFFF);
        in_port = 16'hFFFF;
        repeat (5) cyc();
        read_chk("pre_rst_cap", 0, 2'd3, 32'h0000FFFF);
        chk("pre_rst_irq", 32'(irq_o[0]), 32'h1);
        #2;
        reset   = 1'b1;
        in_port = '0;
        model_reset();
        #1;
        chk("arst_irq", 32'(irq_o[0]), 32'h0);
        read_chk("arst_cap", 0, 2'd3, 32'h0);
        read_chk("arst_mask", 0, 2'd2, 32'h0);
        repeat (2) cyc();
        reset = 1'b0;
        repeat (6) cyc();
        read_chk("no_spur_rise", 0, 2'd3, 32'h0);
        read_chk("no_spur_any", 2, 2'd3, 32'h0);

        // Random traffic against the reference
        for (int n = 0; n < 2000; n++) begin
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom();
            if ($urandom_range(0, 2) == 0) begin
                in_port = in_port ^ (W'(1) << $urandom_range(0, W-1));
            end
            cyc();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
